truth_table_scanner: RTL

Sequential characterizer for 4-input combinational function blocks such as the fabcd family. It sweeps the input vector {a,b,c,d} from 0 to 15 into the function under test and samples the single-bit response s. It then builds the 16-bit truth table, compares it against an expected mask, and streams the set minterm indices out over a valid/ready handshake. This is the receiving/checking end of the exhaustive-vector stimulus used to exercise function blocks.

---
 rtl/truth_table_scanner.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//
// Characterises a 4-input combinational function block. The scanner drives
// every input vector {a,b,c,d} = 0..15 into the block in turn. It samples the
// block's response s and builds the 16-entry truth table from those samples.
// It compares the table against EXPECT_MASK, then streams the indices of the
// set minterms over a valid/ready handshake.
//
// Parameters
//   EXPECT_MASK : expected truth table, bit k = f(k), k = {a,b,c,d} (a is MSB)
//   SETTLE      : cycles each vector is held before s is sampled (1..15)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a scan; only honoured while idle
//   a,b,c,d    out  registered input vector for the function under test
//   s          in   response of the function under test
//   busy       out  high whenever a scan or listing is in progress
//   tbl        out  captured truth table
//   count      out  number of ones in tbl (0..16)
//   match      out  tbl == EXPECT_MASK, valid once done has pulsed
//   idx_valid  out  minterm index available
//   idx        out  minterm index
//   idx_ready  in   consumer accepts idx
//   done       out  one-cycle pulse at the end of a scan
module truth_table_scanner #(
  parameter logic [15:0] EXPECT_MASK = 16'h1894,
  parameter int unsigned SETTLE      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        s,
  output logic        busy,
  output logic [15:0] tbl,
  output logic [4:0]  count,
  output logic        match,
  output logic        idx_valid,
  output logic [3:0]  idx,
  input  logic        idx_ready,
  output logic        done
);

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSample,
    StList,
    StFin
  } state_e;

  // Last value of the settle counter before sampling.
  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  settle_q, settle_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [15:0] tbl_q, tbl_d;
  logic [4:0]  count_q, count_d;
  logic        match_q, match_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      vec_q    <= 4'd0;
      settle_q <= 4'd0;
      ptr_q    <= 4'd0;
      tbl_q    <= 16'd0;
      count_q  <= 5'd0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      ptr_q    <= ptr_d;
      tbl_q    <= tbl_d;
      count_q  <= count_d;
      match_q  <= match_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    ptr_d    = ptr_q;
    tbl_d    = tbl_q;
    count_d  = count_q;
    match_d  = match_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StDrive;
          vec_d    = 4'd0;
          settle_d = 4'd0;
          ptr_d    = 4'd0;
          tbl_d    = 16'd0;
          count_d  = 5'd0;
          match_d  = 1'b0;
        end
      end

      StDrive: begin
        if (settle_q == SettleLast) begin
          settle_d = 4'd0;
          state_d  = StSample;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      StSample: begin
        tbl_d[vec_q] = s;
        count_d      = count_q + {4'd0, s};
        if (vec_q == 4'hf) begin
          // Compare against the table including this final sample.
          match_d = (tbl_d == EXPECT_MASK);
          ptr_d   = 4'd0;
          state_d = StList;
        end else begin
          vec_d   = vec_q + 4'd1;
          state_d = StDrive;
        end
      end

      StList: begin
        // Clear entries are skipped; set entries wait for the consumer.
        if (!tbl_q[ptr_q] || idx_ready) begin
          if (ptr_q == 4'hf) begin
            state_d = StFin;
          end else begin
            ptr_d = ptr_q + 4'd1;
          end
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The vector register drives the function block directly. It keeps its last
  // value (15) after the sweep until the next start or a reset.
  assign {a, b, c, d} = vec_q;

  assign busy      = (state_q != StIdle);
  assign tbl       = tbl_q;
  assign count     = count_q;
  assign match     = match_q;
  assign idx_valid = (state_q == StList) && tbl_q[ptr_q];
  assign idx       = ptr_q;
  assign done      = (state_q == StFin);

endmodule
